// File: rtl/npi_ict_rd.sv
// NPI interconnect read-return path: status FIFO of issued reads, NPI read FIFO popper, per-port beat steering.
// Optional feature macro NPI_ICT_RD_STAT_EN adds a saturating completed-burst counter in npi_ict_rd_state[31:25].
module npi_ict_rd #(
  parameter int C_NUM_PORTS      = 4,
  parameter int C_PIM_DATA_WIDTH = 64,
  parameter int C_RDFIFO_LATENCY = 1,
  parameter int C_STS_AWIDTH     = 3
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [2:0]                  rdsts_nr,
  input  logic [5:0]                  rdsts_len,
  input  logic                        rdsts_wren,
  output logic                        rdsts_afull,
  input  logic [C_PIM_DATA_WIDTH-1:0] PIM_RdFIFO_Data,
  input  logic                        PIM_RdFIFO_Empty,
  output logic                        PIM_RdFIFO_Pop,
  output logic                        PIM_RdFIFO_Flush,
  output logic [C_PIM_DATA_WIDTH-1:0] RspData,
  output logic [C_NUM_PORTS-1:0]      RspPush,
  output logic [C_NUM_PORTS-1:0]      RspLast,
  input  logic [C_NUM_PORTS-1:0]      RspAfull,
  output logic [31:0]                 npi_ict_rd_state
);

  localparam int STS_DEPTH = 1 << C_STS_AWIDTH;
  localparam int STS_CW    = C_STS_AWIDTH + 1;
  localparam logic [3:0] NUM_PORTS_W = 4'(C_NUM_PORTS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [2:0] nr;
    logic       last;
  } tag_t;

  function automatic logic nr_ok(input logic [2:0] nr);
    return {1'b0, nr} < NUM_PORTS_W;
  endfunction

  // ---------------------------------------------------------------------------
  // Status FIFO (first-word-fall-through), entries are {nr, len}
  // ---------------------------------------------------------------------------
  logic [8:0]              sts_mem_q [STS_DEPTH];
  logic [C_STS_AWIDTH-1:0] sts_wr_ptr_q, sts_wr_ptr_d;
  logic [C_STS_AWIDTH-1:0] sts_rd_ptr_q, sts_rd_ptr_d;
  logic [STS_CW-1:0]       sts_cnt_q, sts_cnt_d;
  logic                    sts_empty, sts_full, sts_push, sts_pop;
  logic                    ovf_q, ovf_d;
  logic [8:0]              sts_head;
  logic [2:0]              head_nr;
  logic [5:0]              head_len;

  assign sts_empty = (sts_cnt_q == '0);
  assign sts_full  = (sts_cnt_q == STS_CW'(STS_DEPTH));
  assign sts_push  = rdsts_wren & (~sts_full | sts_pop);
  assign sts_head  = sts_mem_q[sts_rd_ptr_q];
  assign head_nr   = sts_head[8:6];
  assign head_len  = sts_head[5:0];

  assign rdsts_afull = ~Rst & (sts_cnt_q >= STS_CW'(STS_DEPTH - 2));

  // NOTE: storage array carries no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge Clk) begin
    if (sts_push) begin
      sts_mem_q[sts_wr_ptr_q] <= {rdsts_nr, rdsts_len};
    end
  end

  always_comb begin
    sts_wr_ptr_d = sts_wr_ptr_q;
    sts_rd_ptr_d = sts_rd_ptr_q;
    sts_cnt_d    = sts_cnt_q;
    ovf_d        = ovf_q | (rdsts_wren & ~sts_push);
    if (sts_push) sts_wr_ptr_d = sts_wr_ptr_q + 1'b1;
    if (sts_pop)  sts_rd_ptr_d = sts_rd_ptr_q + 1'b1;
    case ({sts_push, sts_pop})
      2'b10:   sts_cnt_d = sts_cnt_q + 1'b1;
      2'b01:   sts_cnt_d = sts_cnt_q - 1'b1;
      default: sts_cnt_d = sts_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst FSM: pull one status entry, then pop its beats from the NPI read FIFO
  // ---------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic [2:0] cur_nr_q, cur_nr_d;
  logic [5:0] beats_q, beats_d;
  logic       badnr_q, badnr_d;
  logic       rd_pop;
  logic [7:0] afull_ext;
  logic       port_afull;

  assign afull_ext  = 8'(RspAfull);
  assign port_afull = afull_ext[cur_nr_q];

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cur_nr_d = cur_nr_q;
    beats_d  = beats_q;
    badnr_d  = badnr_q;
    sts_pop  = 1'b0;
    rd_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sts_empty) begin
          sts_pop = 1'b1;
          // A zero-length entry is consumed without starting a burst.
          if (head_len != 6'd0) begin
            cur_nr_d = head_nr;
            beats_d  = head_len;
            state_d  = S_DATA;
            if (!nr_ok(head_nr)) badnr_d = 1'b1;
          end
        end
      end
      default: begin
        rd_pop = ~PIM_RdFIFO_Empty & ~port_afull;
        if (rd_pop) begin
          beats_d = beats_q - 6'd1;
          if (beats_q == 6'd1) state_d = S_IDLE;
        end
      end
    endcase
  end

  assign PIM_RdFIFO_Pop = rd_pop & ~Rst;

  // ---------------------------------------------------------------------------
  // Tag pipeline aligning {valid, nr, last} with the read data latency
  // ---------------------------------------------------------------------------
  tag_t tag_in, tag_out;

  assign tag_in = '{valid: PIM_RdFIFO_Pop, nr: cur_nr_q, last: (beats_q == 6'd1)};

  generate
    if (C_RDFIFO_LATENCY == 0) begin : g_lat0
      assign tag_out = tag_in;
    end else begin : g_latn
      tag_t tag_pipe_q [C_RDFIFO_LATENCY];
      always_ff @(posedge Clk) begin
        if (Rst) begin
          for (int i = 0; i < C_RDFIFO_LATENCY; i++) tag_pipe_q[i] <= '0;
        end else begin
          tag_pipe_q[0] <= tag_in;
          for (int i = 1; i < C_RDFIFO_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
        end
      end
      assign tag_out = tag_pipe_q[C_RDFIFO_LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registered response outputs; beats of an out-of-range port decode to no strobe
  // ---------------------------------------------------------------------------
  logic [C_NUM_PORTS-1:0]      port_onehot;
  logic [C_NUM_PORTS-1:0]      rsp_push_q, rsp_push_d;
  logic [C_NUM_PORTS-1:0]      rsp_last_q, rsp_last_d;
  logic [C_PIM_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    port_onehot = '0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      if (tag_out.nr == 3'(p)) port_onehot[p] = 1'b1;
    end
    rsp_push_d = tag_out.valid ? port_onehot : '0;
    rsp_last_d = (tag_out.valid & tag_out.last) ? port_onehot : '0;
    rsp_data_d = tag_out.valid ? PIM_RdFIFO_Data : rsp_data_q;
  end

  assign RspData = rsp_data_q;
  assign RspPush = rsp_push_q;
  assign RspLast = rsp_last_q;

  // ---------------------------------------------------------------------------
  // Flush: held through reset and for one cycle after
  // ---------------------------------------------------------------------------
  logic flush_q;

  assign PIM_RdFIFO_Flush = Rst | flush_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    flush_q <= Rst;
    if (Rst) begin
      state_q      <= S_IDLE;
      cur_nr_q     <= '0;
      beats_q      <= '0;
      badnr_q      <= 1'b0;
      ovf_q        <= 1'b0;
      sts_wr_ptr_q <= '0;
      sts_rd_ptr_q <= '0;
      sts_cnt_q    <= '0;
      rsp_push_q   <= '0;
      rsp_last_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_nr_q     <= cur_nr_d;
      beats_q      <= beats_d;
      badnr_q      <= badnr_d;
      ovf_q        <= ovf_d;
      sts_wr_ptr_q <= sts_wr_ptr_d;
      sts_rd_ptr_q <= sts_rd_ptr_d;
      sts_cnt_q    <= sts_cnt_d;
      rsp_push_q   <= rsp_push_d;
      rsp_last_q   <= rsp_last_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug status word
  // ---------------------------------------------------------------------------
  logic [6:0] stat_field;
  logic [3:0] sts_cnt_dbg;

  assign sts_cnt_dbg = 4'(sts_cnt_q);

`ifdef NPI_ICT_RD_STAT_EN
  logic [6:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if ((|rsp_last_d) && (burst_cnt_q != 7'h7f)) burst_cnt_d = burst_cnt_q + 7'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end

  assign stat_field = burst_cnt_q;
`else
  assign stat_field = 7'd0;
`endif

  assign npi_ict_rd_state = {stat_field, PIM_RdFIFO_Empty, afull_ext, sts_cnt_dbg,
                             beats_q, cur_nr_q, badnr_q, ovf_q, state_q};

endmodule

// File: tb/tb_npi_ict_rd.sv
// Scoreboard bench for npi_ict_rd: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_npi_ict_rd;

  localparam int NP  = 4;
  localparam int DW  = 64;
  localparam int LAT = 1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [2:0]    rdsts_nr = '0;
  logic [5:0]    rdsts_len = '0;
  logic          rdsts_wren = 1'b0;
  logic          rdsts_afull;
  logic [DW-1:0] PIM_RdFIFO_Data = '0;
  logic          PIM_RdFIFO_Empty;
  logic          PIM_RdFIFO_Pop;
  logic          PIM_RdFIFO_Flush;
  logic [DW-1:0] RspData;
  logic [NP-1:0] RspPush;
  logic [NP-1:0] RspLast;
  logic [NP-1:0] RspAfull = '0;
  logic [31:0]   npi_ict_rd_state;

  npi_ict_rd #(
    .C_NUM_PORTS(NP), .C_PIM_DATA_WIDTH(DW), .C_RDFIFO_LATENCY(LAT), .C_STS_AWIDTH(3)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .rdsts_nr(rdsts_nr), .rdsts_len(rdsts_len), .rdsts_wren(rdsts_wren), .rdsts_afull(rdsts_afull),
    .PIM_RdFIFO_Data(PIM_RdFIFO_Data), .PIM_RdFIFO_Empty(PIM_RdFIFO_Empty),
    .PIM_RdFIFO_Pop(PIM_RdFIFO_Pop), .PIM_RdFIFO_Flush(PIM_RdFIFO_Flush),
    .RspData(RspData), .RspPush(RspPush), .RspLast(RspLast), .RspAfull(RspAfull),
    .npi_ict_rd_state(npi_ict_rd_state)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [NP-1:0] push;
    logic [NP-1:0] last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  // NPI read FIFO model: data appears one cycle after the pop, flush discards everything loaded
  logic [DW-1:0] rd_mem [1024];
  int loaded_cnt = 0;
  int popped_cnt = 0;
  int cyc = 0;

  assign PIM_RdFIFO_Empty = (loaded_cnt == popped_cnt);

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    if (PIM_RdFIFO_Flush) begin
      popped_cnt <= loaded_cnt;
    end else if (PIM_RdFIFO_Pop && !PIM_RdFIFO_Empty) begin
      PIM_RdFIFO_Data <= rd_mem[popped_cnt % 1024];
      popped_cnt      <= popped_cnt + 1;
    end
  end

  // Monitor
  int push_cnt = 0;
  int pop_seen = 0;
  int push_cyc_log [256];
  int pop_cyc_log  [256];

  always @(negedge Clk) begin
    exp_t e;
    if (PIM_RdFIFO_Pop) begin
      pop_cyc_log[pop_seen % 256] = cyc;
      pop_seen++;
    end
    if (RspPush != '0 || RspLast != '0) begin
      push_cyc_log[push_cnt % 256] = cyc;
      push_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'({RspPush, RspLast}), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_push", 64'(RspPush), 64'(e.push));
        check("rsp_last", 64'(RspLast), 64'(e.last));
        check("rsp_data", RspData, e.data);
      end
    end
  end

  task automatic load_burst(input logic [2:0] nr, input int len, input logic [7:0] tag, input int n_exp);
    logic [DW-1:0] d;
    logic [NP-1:0] oh;
    exp_t e;
    oh = '0;
    if (int'(nr) < NP) oh[nr] = 1'b1;
    for (int i = 0; i < len; i++) begin
      d = {tag, 24'h5a5a5a, 32'(i + 1)};
      rd_mem[loaded_cnt % 1024] = d;
      loaded_cnt++;
      if (i < n_exp && oh != '0) begin
        e.push = oh;
        e.last = (i == len - 1) ? oh : '0;
        e.data = d;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic sts_write(input logic [2:0] nr, input logic [5:0] len);
    rdsts_nr   = nr;
    rdsts_len  = len;
    rdsts_wren = 1'b1;
    @(posedge Clk);
    #1;
    rdsts_wren = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      #1;
      if (sb_q.size() == 0 && npi_ict_rd_state[0] == 1'b0 && npi_ict_rd_state[15:12] == 4'd0 &&
          loaded_cnt == popped_cnt) done = 1'b1;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_pushes(input string name, input int target, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      #1;
      if (push_cnt >= target) done = 1'b1;
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base_push, base_pop, base_popped, hold_pushes;
    logic pop_in_hold;

    // Reset: flush during reset and one cycle after, everything else quiet
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("flush_in_rst", 64'(PIM_RdFIFO_Flush), 64'd1);
    check("pop_in_rst", 64'(PIM_RdFIFO_Pop), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    check("flush_after_rst", 64'(PIM_RdFIFO_Flush), 64'd1);
    check("rst_state", 64'(npi_ict_rd_state), 64'h0100_0000);
    check("rst_push", 64'({RspPush, RspLast}), 64'd0);
    check("rst_data", RspData, 64'd0);
    check("rst_afull", 64'(rdsts_afull), 64'd0);
    @(posedge Clk);
    #1;
    check("flush_released", 64'(PIM_RdFIFO_Flush), 64'd0);

    // {2,8}: eight beats to port 2, first push two cycles after first pop
    base_push   = push_cnt;
    base_pop    = pop_seen;
    base_popped = popped_cnt;
    load_burst(3'd2, 8, 8'h10, 8);
    sts_write(3'd2, 6'd8);
    wait_idle("t1_done", 200);
    check("t1_pops", 64'(popped_cnt - base_popped), 64'd8);
    check("t1_pushes", 64'(push_cnt - base_push), 64'd8);
    check("t1_latency", 64'(push_cyc_log[base_push % 256] - pop_cyc_log[base_pop % 256]), 64'(LAT + 1));

    // {1,4} then {3,1} back-to-back: order kept, one idle cycle between bursts
    base_push = push_cnt;
    load_burst(3'd1, 4, 8'h20, 4);
    load_burst(3'd3, 1, 8'h21, 1);
    sts_write(3'd1, 6'd4);
    sts_write(3'd3, 6'd1);
    wait_idle("t2_done", 200);
    check("t2_pushes", 64'(push_cnt - base_push), 64'd5);
    check("t2_span", 64'(push_cyc_log[(base_push + 4) % 256] - push_cyc_log[base_push % 256]), 64'd5);

    // {0,16} with port 0 almost-full after beat 5 for 10 cycles
    base_push = push_cnt;
    load_burst(3'd0, 16, 8'h30, 16);
    sts_write(3'd0, 6'd16);
    wait_pushes("t3_wait5", base_push + 5, 200);
    RspAfull = 4'b0001;
    pop_in_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (PIM_RdFIFO_Pop) pop_in_hold = 1'b1;
      @(negedge Clk);
    end
    hold_pushes = push_cnt - (base_push + 5);
    RspAfull = 4'b0000;
    check("t3_pop_held", 64'(pop_in_hold), 64'd0);
    check("t3_hold_pushes_le", 64'(hold_pushes <= LAT + 2), 64'd1);
    wait_idle("t3_done", 300);
    check("t3_pushes", 64'(push_cnt - base_push), 64'd16);

    // Status FIFO fill: blocker burst waits for data, then 9 zero-length writes
    sts_write(3'd0, 6'd2);
    repeat (3) @(posedge Clk);
    #1;
    check("t4_blocked", 64'(npi_ict_rd_state[0]), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      sts_write(3'd1, 6'd0);
      check($sformatf("t4_cnt%0d", k), 64'(npi_ict_rd_state[15:12]), 64'((k > 8) ? 8 : k));
      if (k == 5) check("t4_afull_at5", 64'(rdsts_afull), 64'd0);
      if (k == 6) check("t4_afull_at6", 64'(rdsts_afull), 64'd1);
      if (k == 8) check("t4_ovf_at8", 64'(npi_ict_rd_state[1]), 64'd0);
      if (k == 9) check("t4_ovf_at9", 64'(npi_ict_rd_state[1]), 64'd1);
    end
    base_push = push_cnt;
    load_burst(3'd0, 2, 8'h40, 2);
    wait_idle("t4_done", 200);
    check("t4_pushes", 64'(push_cnt - base_push), 64'd2);
    check("t4_ovf_sticky", 64'(npi_ict_rd_state[1]), 64'd1);

    // {6,2}: beats popped and dropped, badnr set
    base_push   = push_cnt;
    base_popped = popped_cnt;
    load_burst(3'd6, 2, 8'h50, 0);
    sts_write(3'd6, 6'd2);
    wait_idle("t5_done", 200);
    check("t5_pops", 64'(popped_cnt - base_popped), 64'd2);
    check("t5_no_push", 64'(push_cnt - base_push), 64'd0);
    check("t5_badnr", 64'(npi_ict_rd_state[2]), 64'd1);

    // Reset mid-burst of {2,8} after the third pop
    base_push   = push_cnt;
    base_popped = popped_cnt;
    load_burst(3'd2, 8, 8'h60, 2);
    sts_write(3'd2, 6'd8);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge Clk);
        #1;
        if (popped_cnt - base_popped >= 3) hit = 1'b1;
      end
      check("t6_reach_beat3", 64'(hit), 64'd1);
    end
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("t6_push_cleared", 64'({RspPush, RspLast}), 64'd0);
    check("t6_flush_in_rst", 64'(PIM_RdFIFO_Flush), 64'd1);
    check("t6_state", 64'(npi_ict_rd_state), 64'h0100_0000);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    check("t6_flush_after", 64'(PIM_RdFIFO_Flush), 64'd1);
    repeat (5) @(posedge Clk);
    #1;
    check("t6_flush_released", 64'(PIM_RdFIFO_Flush), 64'd0);
    check("t6_pushes", 64'(push_cnt - base_push), 64'd2);
    check("t6_sb_drained", 64'(sb_q.size()), 64'd0);
    check("t6_idle", 64'(npi_ict_rd_state[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
